regfile_scoreboard: RTL and testbench
=====================================

# regfile_scoreboard

Parametrised multi-read-port register file for the MIPS datapath with write-to-read bypass, a hardwired zero register and a per-register pending-write scoreboard. Decode issues destination registers, and writeback retires them. Each read port reports whether its source register still has outstanding writes, so the hazard unit can stall on multicycle and load results instead of relying on fixed pipeline timing.

## Interface
- DATA_W, 32, register width in bits
- ADDR_W, 5, address width; depth = 2**ADDR_W
- NREAD, 2, number of read ports
- PEND_W, 2, pending-counter width; max outstanding writes per register = 2**PEND_W-1
- ZERO_REG, 1, 1 = register 0 reads 0 and ignores writes/issues
- clk  in  1  clock, all state on rising edge
- reset  in  1  asynchronous, active-high; clears all state
- ra  in  NREAD*ADDR_W  read addresses, port i at bits [i*ADDR_W +: ADDR_W]
- rd  out  NREAD*DATA_W  read data, port i at [i*DATA_W +: DATA_W]
- rbusy  out  NREAD  port i source has outstanding writes
- we  in  1  write enable
- wa  in  ADDR_W  write address
- wd  in  DATA_W  write data
- wretire  in  1  qualified by we: this write retires one issued op on wa
- iss_valid  in  1  decode requests tracking of destination iss_addr
- iss_addr  in  ADDR_W  destination register being issued
- iss_ready  out  1  issue accepted when iss_valid & iss_ready
- err  out  1  sticky: retire on register with zero pending count

## Operation
- Storage: 2**ADDR_W x DATA_W array. Write commits at posedge when we=1 and not (ZERO_REG & wa==0).
- Read port i: combinational. If ZERO_REG & ra_i==0 then 0. Otherwise, if we & wa==ra_i and the write is not suppressed, then wd (bypass). Otherwise the array entry.
- Scoreboard: cnt[r] is a PEND_W-bit counter per register.
  - inc = iss_valid & iss_ready & tracked(iss_addr).
  - dec = we & wretire & tracked(wa) & cnt[wa]!=0.
  - tracked(a) = !(ZERO_REG & a==0).
  - Same register with inc and dec in one cycle: count unchanged.
  - Different registers with inc and dec: both apply.
- iss_ready = (cnt[iss_addr] != all-ones) | !tracked(iss_addr). It is combinational from iss_addr and state only, and ignores a same-cycle retire.
- rbusy[i] = tracked(ra_i) & (cnt[ra_i] - (same-cycle dec on ra_i ? 1 : 0)) != 0. A retire in the current cycle that drops the count to 0 clears busy in that cycle, matching the data bypass.
- err is set at posedge when we & wretire & tracked(wa) & cnt[wa]==0. The count stays 0 and the data write still commits. err clears only on reset.
- Writes with wretire=0 update data only; counters are untouched.

## Timing
- Reset (async assert, sync-safe deassert): array = 0, all cnt = 0, err = 0.
- While reset is high, writes and issues are ignored and bypass is disabled. Outputs are rd = 0, rbusy = 0, iss_ready = 1, err = 0.
- Read latency 0 cycles. Write visible through bypass in the same cycle and from the array from the next cycle.
- An issue accepted in cycle t raises rbusy for that register from cycle t+1.
- Reset mid-operation discards all pending counts immediately. No retire is owed afterwards.
- All NREAD ports may read the same address simultaneously with identical results.

## Structure
- Package regfile_pkg: default parameter values and a tracked(addr) helper function.
- Sub-module regfile_pend_ctr: one saturating up/down counter with inc, dec, zero-detect and underflow flag. It is generated 2**ADDR_W times.
- Read ports are built with a generate loop over NREAD.

## Test plan
- Reset, then read ports 0..1 at addresses 3 and 31 -> rd=0, rbusy=0, iss_ready=1, err=0.
- Write wd=0xDEADBEEF to wa=7 with ra0=7 in the same cycle -> rd0=0xDEADBEEF that cycle and the next; write to wa=0 -> ra=0 still reads 0.
- Issue r5 three times (PEND_W=2) -> iss_ready=0 with iss_addr=5. One retire write of r5 -> iss_ready=1 next cycle and rbusy stays 1. Two more retires -> rbusy drops combinationally in the cycle of the last retire, with rd showing the bypassed wd.
- Issue r9 and retire r9 in the same cycle with cnt[9]=1 -> cnt stays 1, rbusy=1 next cycle.
- Retire r12 with cnt=0 -> err=1 next cycle, stays 1, data 0x12 written to r12.
- Issue r4 twice, assert reset mid-sequence -> rbusy=0 and array=0 immediately. After release, a read of r4 returns 0 with rbusy=0.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared defaults and helpers for the scoreboarded MIPS register file.
package regfile_pkg;

  localparam int DATA_W_DEF   = 32;
  localparam int ADDR_W_DEF   = 5;
  localparam int NREAD_DEF    = 2;
  localparam int PEND_W_DEF   = 2;
  localparam bit ZERO_REG_DEF = 1'b1;

  // A register is tracked unless it is the hardwired zero register.
  function automatic logic tracked(input logic zero_reg, input logic addr_is_zero);
    return !(zero_reg && addr_is_zero);
  endfunction

endpackage

// File: rtl/regfile_pend_ctr.sv
// Saturating pending-write counter for one register; inc and dec together hold the count.
module regfile_pend_ctr
  import regfile_pkg::*;
#(
  parameter int PEND_W = PEND_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              inc,
  input  logic              dec,
  output logic [PEND_W-1:0] cnt,
  output logic              zero,
  output logic              full,
  output logic              underflow
);

  logic [PEND_W-1:0] cnt_q;
  logic [PEND_W-1:0] cnt_d;
  logic              inc_ok;
  logic              dec_ok;

  assign zero      = (cnt_q == '0);
  assign full      = (cnt_q == '1);
  assign inc_ok    = inc & ~full;
  assign dec_ok    = dec & ~zero;
  assign underflow = dec & zero;
  assign cnt       = cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (inc_ok && !dec_ok) begin
      cnt_d = cnt_q + PEND_W'(1);
    end else if (dec_ok && !inc_ok) begin
      cnt_d = cnt_q - PEND_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/regfile_scoreboard.sv
// Multi-port register file with write bypass, zero register and per-register
// pending-write scoreboard feeding the hazard unit.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int NREAD    = NREAD_DEF,
  parameter int PEND_W   = PEND_W_DEF,
  parameter bit ZERO_REG = ZERO_REG_DEF
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NREAD*ADDR_W-1:0] ra,
  output logic [NREAD*DATA_W-1:0] rd,
  output logic [NREAD-1:0]        rbusy,
  input  logic                    we,
  input  logic [ADDR_W-1:0]       wa,
  input  logic [DATA_W-1:0]       wd,
  input  logic                    wretire,
  input  logic                    iss_valid,
  input  logic [ADDR_W-1:0]       iss_addr,
  output logic                    iss_ready,
  output logic                    err
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];
  logic              err_q;
  logic              err_d;

  logic [PEND_W-1:0] cnt [DEPTH];
  logic [DEPTH-1:0]  cnt_zero;
  logic [DEPTH-1:0]  cnt_full;
  logic [DEPTH-1:0]  cnt_uflow;
  logic [DEPTH-1:0]  inc_vec;
  logic [DEPTH-1:0]  dec_vec;

  logic wr_ok;
  logic ret_ok;
  logic iss_trk;
  logic iss_ok;

  // Reset gates every write, retire and issue so nothing leaks through bypass.
  assign wr_ok     = we & ~reset & tracked(ZERO_REG, wa == '0);
  assign ret_ok    = wr_ok & wretire;
  assign iss_trk   = tracked(ZERO_REG, iss_addr == '0);
  assign iss_ready = reset | ~iss_trk | ~cnt_full[iss_addr];
  assign iss_ok    = iss_valid & iss_ready & iss_trk & ~reset;

  for (genvar r = 0; r < DEPTH; r++) begin : g_pend
    assign inc_vec[r] = iss_ok & (iss_addr == ADDR_W'(r));
    assign dec_vec[r] = ret_ok & (wa == ADDR_W'(r));

    regfile_pend_ctr #(
      .PEND_W(PEND_W)
    ) u_ctr (
      .clk      (clk),
      .reset    (reset),
      .inc      (inc_vec[r]),
      .dec      (dec_vec[r]),
      .cnt      (cnt[r]),
      .zero     (cnt_zero[r]),
      .full     (cnt_full[r]),
      .underflow(cnt_uflow[r])
    );
  end

  always_comb begin
    mem_d = mem_q;
    if (wr_ok) begin
      mem_d[wa] = wd;
    end
  end

  assign err_d = err_q | (|cnt_uflow);
  assign err   = err_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      err_q <= 1'b0;
    end else begin
      mem_q <= mem_d;
      err_q <= err_d;
    end
  end

  // Busy looks through a same-cycle retire so it drops together with the data bypass.
  for (genvar i = 0; i < NREAD; i++) begin : g_rd
    logic [ADDR_W-1:0] rd_addr;
    logic              rd_trk;
    logic              rd_byp;
    logic              rd_dec;
    logic [PEND_W-1:0] cnt_left;

    assign rd_addr  = ra[i*ADDR_W +: ADDR_W];
    assign rd_trk   = tracked(ZERO_REG, rd_addr == '0);
    assign rd_byp   = wr_ok & (wa == rd_addr);
    assign rd_dec   = ret_ok & (wa == rd_addr) & ~cnt_zero[rd_addr];
    assign cnt_left = cnt[rd_addr] - PEND_W'(rd_dec);

    assign rd[i*DATA_W +: DATA_W] = (reset || !rd_trk) ? '0 :
                                    rd_byp             ? wd : mem_q[rd_addr];
    assign rbusy[i] = ~reset & rd_trk & (cnt_left != '0);
  end

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed bench for regfile_scoreboard: array/counter model checked every cycle
// plus literal expectations at the interesting points.
module tb_regfile_scoreboard;

  logic        clk;
  logic        reset;
  logic [9:0]  ra;
  logic [63:0] rd;
  logic [1:0]  rbusy;
  logic        we;
  logic [4:0]  wa;
  logic [31:0] wd;
  logic        wretire;
  logic        iss_valid;
  logic [4:0]  iss_addr;
  logic        iss_ready;
  logic        err;

  int total = 0;
  int bad   = 0;

  bit [31:0] mdl_mem [32];
  int        mdl_cnt [32];
  bit        mdl_err;

  regfile_scoreboard dut (
    .clk      (clk),
    .reset    (reset),
    .ra       (ra),
    .rd       (rd),
    .rbusy    (rbusy),
    .we       (we),
    .wa       (wa),
    .wd       (wd),
    .wretire  (wretire),
    .iss_valid(iss_valid),
    .iss_addr (iss_addr),
    .iss_ready(iss_ready),
    .err      (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Model: plain arrays updated from the rules, cleared asynchronously by reset.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) begin
        mdl_mem[i] = 32'd0;
        mdl_cnt[i] = 0;
      end
      mdl_err = 1'b0;
    end else begin
      bit inc;
      bit dec;
      int ia;
      int wi;
      ia  = int'(iss_addr);
      wi  = int'(wa);
      inc = iss_valid && ia != 0 && mdl_cnt[ia] < 3;
      dec = we && wretire && wi != 0 && mdl_cnt[wi] > 0;
      if (we && wretire && wi != 0 && mdl_cnt[wi] == 0) mdl_err = 1'b1;
      if (inc) mdl_cnt[ia] = mdl_cnt[ia] + 1;
      if (dec) mdl_cnt[wi] = mdl_cnt[wi] - 1;
      if (we && wi != 0) mdl_mem[wi] = wd;
    end
  end

  always @(negedge clk) begin
    bit e_ready;
    for (int i = 0; i < 2; i++) begin
      int          a;
      int          left;
      logic [31:0] e_rd;
      bit          e_busy;
      a = int'(ra[i*5 +: 5]);
      if (reset || a == 0) e_rd = 32'd0;
      else if (we && int'(wa) == a) e_rd = wd;
      else e_rd = mdl_mem[a];
      left = mdl_cnt[a] - ((we && wretire && int'(wa) == a && mdl_cnt[a] > 0) ? 1 : 0);
      e_busy = !reset && a != 0 && left > 0;
      chk($sformatf("model_rd%0d", i), rd[i*32 +: 32], e_rd);
      chk($sformatf("model_rbusy%0d", i), 32'(rbusy[i]), 32'(e_busy));
    end
    e_ready = reset || iss_addr == 5'd0 || mdl_cnt[int'(iss_addr)] < 3;
    chk("model_iss_ready", 32'(iss_ready), 32'(e_ready));
    chk("model_err", 32'(err), 32'(mdl_err));
  end

  initial begin
    reset = 1'b1; we = 1'b0; wretire = 1'b0; wa = 5'd0; wd = 32'd0;
    iss_valid = 1'b0; iss_addr = 5'd0; ra = {5'd31, 5'd3};
    repeat (2) @(posedge clk);
    #1;
    chk("rst_rd0", rd[31:0], 32'd0);
    chk("rst_rd1", rd[63:32], 32'd0);
    chk("rst_rbusy", 32'(rbusy), 32'd0);
    chk("rst_iss_ready", 32'(iss_ready), 32'd1);
    chk("rst_err", 32'(err), 32'd0);
    reset = 1'b0;
    step(); #1;
    chk("rel_rd1", rd[63:32], 32'd0);
    chk("rel_iss_ready", 32'(iss_ready), 32'd1);

    // write bypass, then array read; zero register ignores writes
    step(); ra = {5'd31, 5'd7}; we = 1'b1; wa = 5'd7; wd = 32'hDEADBEEF; #1;
    chk("byp_rd0", rd[31:0], 32'hDEADBEEF);
    step(); we = 1'b0; #1;
    chk("arr_rd0", rd[31:0], 32'hDEADBEEF);
    step(); we = 1'b1; wa = 5'd0; wd = 32'hFFFFFFFF; ra = {5'd0, 5'd0}; #1;
    chk("zero_byp_rd0", rd[31:0], 32'd0);
    chk("zero_byp_rd1", rd[63:32], 32'd0);
    step(); we = 1'b0; #1;
    chk("zero_arr_rd0", rd[31:0], 32'd0);

    // r5: fill to saturation, then retire down to zero
    step(); ra = {5'd31, 5'd5}; iss_valid = 1'b1; iss_addr = 5'd5; #1;
    chk("iss1_busy_same_cycle", 32'(rbusy[0]), 32'd0);
    step(); #1;
    chk("iss2_busy", 32'(rbusy[0]), 32'd1);
    step(); #1;
    chk("iss3_ready", 32'(iss_ready), 32'd1);
    step(); #1;
    chk("full_ready", 32'(iss_ready), 32'd0);
    step(); iss_valid = 1'b0; we = 1'b1; wretire = 1'b1; wa = 5'd5; wd = 32'h55; #1;
    chk("ret1_ready_ignores_retire", 32'(iss_ready), 32'd0);
    chk("ret1_busy", 32'(rbusy[0]), 32'd1);
    chk("ret1_rd0", rd[31:0], 32'h55);
    step(); we = 1'b0; wretire = 1'b0; #1;
    chk("after_ret1_ready", 32'(iss_ready), 32'd1);
    chk("after_ret1_busy", 32'(rbusy[0]), 32'd1);
    step(); we = 1'b1; wretire = 1'b1; wd = 32'h56; #1;
    chk("ret2_busy", 32'(rbusy[0]), 32'd1);
    step(); wd = 32'h57; #1;
    chk("ret3_busy_drops", 32'(rbusy[0]), 32'd0);
    chk("ret3_rd0", rd[31:0], 32'h57);
    step(); we = 1'b0; wretire = 1'b0; #1;
    chk("r5_idle_busy", 32'(rbusy[0]), 32'd0);
    chk("r5_idle_rd0", rd[31:0], 32'h57);
    chk("r5_idle_err", 32'(err), 32'd0);

    // r9: issue and retire in the same cycle with count 1
    step(); ra = {5'd31, 5'd9}; iss_valid = 1'b1; iss_addr = 5'd9;
    step(); we = 1'b1; wretire = 1'b1; wa = 5'd9; wd = 32'h9; #1;
    chk("r9_same_cycle_busy", 32'(rbusy[0]), 32'd0);
    step(); iss_valid = 1'b0; we = 1'b0; wretire = 1'b0; #1;
    chk("r9_next_busy", 32'(rbusy[0]), 32'd1);

    // different registers: issue r11 while retiring r10
    step(); ra = {5'd11, 5'd10}; iss_valid = 1'b1; iss_addr = 5'd10;
    step(); iss_addr = 5'd11; we = 1'b1; wretire = 1'b1; wa = 5'd10; wd = 32'hA;
    step(); iss_valid = 1'b0; we = 1'b0; wretire = 1'b0; #1;
    chk("r10_busy", 32'(rbusy[0]), 32'd0);
    chk("r11_busy", 32'(rbusy[1]), 32'd1);
    step(); we = 1'b1; wa = 5'd11; wd = 32'hB;
    step(); we = 1'b0; #1;
    chk("data_only_busy", 32'(rbusy[1]), 32'd1);
    chk("data_only_rd1", rd[63:32], 32'hB);

    // r12 retire with nothing pending
    step(); ra = {5'd31, 5'd12}; we = 1'b1; wretire = 1'b1; wa = 5'd12; wd = 32'h12; #1;
    chk("uflow_err_same_cycle", 32'(err), 32'd0);
    step(); we = 1'b0; wretire = 1'b0; #1;
    chk("uflow_err", 32'(err), 32'd1);
    chk("uflow_rd0", rd[31:0], 32'h12);
    step(); #1;
    chk("uflow_err_sticky", 32'(err), 32'd1);

    step(); ra = {5'd7, 5'd7}; #1;
    chk("same_addr_rd0", rd[31:0], 32'hDEADBEEF);
    chk("same_addr_rd1", rd[63:32], 32'hDEADBEEF);

    // r4 pending, then reset mid-cycle
    step(); iss_valid = 1'b1; iss_addr = 5'd4; ra = {5'd7, 5'd4};
    step();
    step(); iss_valid = 1'b0; #1;
    chk("r4_busy", 32'(rbusy[0]), 32'd1);
    #1 reset = 1'b1;
    #1;
    chk("midrst_busy", 32'(rbusy[0]), 32'd0);
    chk("midrst_rd1", rd[63:32], 32'd0);
    chk("midrst_err", 32'(err), 32'd0);
    chk("midrst_ready", 32'(iss_ready), 32'd1);
    step(); step(); reset = 1'b0; #1;
    chk("postrst_rd0", rd[31:0], 32'd0);
    chk("postrst_busy", 32'(rbusy[0]), 32'd0);
    chk("postrst_rd1", rd[63:32], 32'd0);
    chk("postrst_err", 32'(err), 32'd0);
    step(); step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
